solver_dma_slave: RTL and testbench

AXI4-Stream slave that receives lattice initialisation data (one 64-bit cell word per beat) from the DMA MM2S channel and writes it sequentially into the lattice RAM. It is the inbound counterpart of the solver's outbound DMA master. It sits between the AXI DMA and the RAM write port, and is armed by solver control before each load. It enforces frame length against DEPTH and reports completion and errors back to control.

---
 rtl/solver_dma_slave.sv | 125 ++++++++++++
 tb/tb_solver_dma_slave.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solver_dma_slave.sv
// solver_dma_slave: AXI4-Stream slave that loads lattice cell words into the
// lattice RAM. It writes them in order, enforces the frame length against
// DEPTH, and reports completion and length errors to solver control.
// Optional build macro: STRB_CHECK_EN adds a sticky strb_error output, which
// flags RECV beats whose byte strobes are not all ones.
module solver_dma_slave #(
  parameter int unsigned DEPTH                  = 2500,
  parameter int unsigned ADDRESS_WIDTH          = 12,
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                start,
  input  logic                                pause,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   ram_din,
  output logic                                ram_wen,
  output logic [ADDRESS_WIDTH-1:0]            ram_addr,
  output logic                                busy,
  output logic                                load_done,
  output logic                                len_error,
  output logic [ADDRESS_WIDTH-1:0]            beat_count
`ifdef STRB_CHECK_EN
  ,
  output logic                                strb_error
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

  state_t state;
  logic   beat_c;

  // pause is combinational into tready so the solver can take the RAM back immediately
  assign s00_axis_tready = ((state == RECV) || (state == DRAIN)) && !pause;
  assign beat_c          = s00_axis_tvalid && s00_axis_tready;

`ifndef STRB_CHECK_EN
  // Strobes only matter in the checking build
  logic unused_tstrb;
  assign unused_tstrb = ^s00_axis_tstrb;
`endif

  // Load FSM: registers the RAM write one cycle after each accepted RECV beat
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state      <= IDLE;
      ram_din    <= '0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      len_error  <= 1'b0;
      beat_count <= '0;
`ifdef STRB_CHECK_EN
      strb_error <= 1'b0;
`endif
    end else begin
      ram_wen   <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RECV;
            busy       <= 1'b1;
            beat_count <= '0;
            len_error  <= 1'b0;
`ifdef STRB_CHECK_EN
            strb_error <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (beat_c) begin
            ram_wen    <= 1'b1;
            ram_addr   <= beat_count;
            ram_din    <= s00_axis_tdata;
            beat_count <= beat_count + ADDRESS_WIDTH'(1);
`ifdef STRB_CHECK_EN
            if (s00_axis_tstrb != '1) begin
              strb_error <= 1'b1;
            end
`endif
            if (beat_count == LAST_IDX) begin
              if (s00_axis_tlast) begin
                state     <= DONE;
                busy      <= 1'b0;
                load_done <= 1'b1;
              end else begin
                // Over-long frame: swallow the rest without writing
                state     <= DRAIN;
                len_error <= 1'b1;
              end
            end else if (s00_axis_tlast) begin
              state     <= DONE;
              busy      <= 1'b0;
              load_done <= 1'b1;
              len_error <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (beat_c && s00_axis_tlast) begin
            state     <= DONE;
            busy      <= 1'b0;
            load_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solver_dma_slave.sv
// Directed testbench for solver_dma_slave with DEPTH=8.
module tb_solver_dma_slave;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 64;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          pause;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tlast;
  logic          tready;
  logic [DW-1:0] ram_din;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic          busy;
  logic          load_done;
  logic          len_error;
  logic [AW-1:0] beat_count;
`ifdef STRB_CHECK_EN
  logic          strb_error;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            wc_q[$];
  int            done_cnt = 0;
  int            done_cyc = -1;

  solver_dma_slave #(
    .DEPTH(DEPTH),
    .ADDRESS_WIDTH(AW),
    .C_S00_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_aresetn(rst_n),
    .start(start),
    .pause(pause),
    .s00_axis_tvalid(tvalid),
    .s00_axis_tdata(tdata),
    .s00_axis_tstrb(tstrb),
    .s00_axis_tlast(tlast),
    .s00_axis_tready(tready),
    .ram_din(ram_din),
    .ram_wen(ram_wen),
    .ram_addr(ram_addr),
    .busy(busy),
    .load_done(load_done),
    .len_error(len_error),
    .beat_count(beat_count)
`ifdef STRB_CHECK_EN
    ,
    .strb_error(strb_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/completion log sampled mid-cycle
  always @(negedge clk) begin
    if (ram_wen === 1'b1) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_din);
      wc_q.push_back(cyc);
    end
    if (load_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_log;
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // Present n beats with tvalid held, data base+i, tlast on beat last_at
  task automatic send_beats(input int n, input int last_at, input logic [DW-1:0] base);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 100) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = base + DW'(i);
      tlast  = (i == last_at);
      #1;
      if (tready === 1'b1) i++;
      guard++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL send_timeout accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ram_wen !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl wen=%b busy=%b done=%b required 0 0 0", ram_wen, busy, load_done);
    end
    checks++;
    if (len_error !== 1'b0 || beat_count !== 4'd0 || tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_status len_err=%b count=%0d tready=%b required 0 0 0", len_error, beat_count, tready);
    end
    checks++;
    if (ram_addr !== 4'd0 || ram_din !== 64'd0) begin
      failures++;
      $display("FAIL reset_ram addr=%0d din=%h required 0 0", ram_addr, ram_din);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_frame;
    int nbad;
    clear_log();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL clean_busy got=%b required=1", busy);
    end
    send_beats(8, 7, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    nbad = 0;
    foreach (wa_q[k]) begin
      if (wa_q[k] !== AW'(k) || wd_q[k] !== DW'(k) || wc_q[k] != wc_q[0] + k) nbad++;
    end
    checks++;
    if (wa_q.size() != 8 || nbad != 0) begin
      failures++;
      $display("FAIL clean_writes count=%0d bad=%0d required count=8 bad=0", wa_q.size(), nbad);
    end
    checks++;
    if (done_cnt != 1 || wc_q.size() == 0 || done_cyc != wc_q[wc_q.size()-1]) begin
      failures++;
      $display("FAIL clean_done pulses=%0d cyc=%0d required pulses=1 at last write cycle", done_cnt, done_cyc);
    end
    checks++;
    if (len_error !== 1'b0 || beat_count !== 4'd8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clean_status len_err=%b count=%0d busy=%b required 0 8 0", len_error, beat_count, busy);
    end
  endtask

  task automatic test_short_frame;
    int nbad;
    clear_log();
    pulse_start();
    send_beats(5, 4, 64'h100);
    repeat (3) @(negedge clk);
    #1;
    nbad = 0;
    foreach (wa_q[k]) begin
      if (wa_q[k] !== AW'(k) || wd_q[k] !== 64'h100 + DW'(k)) nbad++;
    end
    checks++;
    if (wa_q.size() != 5 || nbad != 0) begin
      failures++;
      $display("FAIL short_writes count=%0d bad=%0d required count=5 bad=0", wa_q.size(), nbad);
    end
    checks++;
    if (len_error !== 1'b1 || done_cnt != 1 || busy !== 1'b0 || tready !== 1'b0) begin
      failures++;
      $display("FAIL short_status len_err=%b pulses=%0d busy=%b tready=%b required 1 1 0 0",
               len_error, done_cnt, busy, tready);
    end
    checks++;
    if (beat_count !== 4'd5) begin
      failures++;
      $display("FAIL short_count got=%0d required=5", beat_count);
    end
  endtask

  task automatic test_long_frame;
    int nbad;
    clear_log();
    pulse_start();
    checks++;
    if (len_error !== 1'b0) begin
      failures++;
      $display("FAIL long_start_clear len_err=%b required=0", len_error);
    end
    send_beats(11, 10, 64'h200);
    repeat (3) @(negedge clk);
    #1;
    nbad = 0;
    foreach (wa_q[k]) begin
      if (wa_q[k] !== AW'(k) || wd_q[k] !== 64'h200 + DW'(k)) nbad++;
    end
    checks++;
    if (wa_q.size() != 8 || nbad != 0) begin
      failures++;
      $display("FAIL long_writes count=%0d bad=%0d required count=8 bad=0", wa_q.size(), nbad);
    end
    checks++;
    if (done_cnt != 1 || wc_q.size() == 0 || done_cyc != wc_q[wc_q.size()-1] + 3) begin
      failures++;
      $display("FAIL long_done pulses=%0d cyc=%0d required pulses=1 three cycles after last write",
               done_cnt, done_cyc);
    end
    checks++;
    if (len_error !== 1'b1 || beat_count !== 4'd8) begin
      failures++;
      $display("FAIL long_status len_err=%b count=%0d required 1 8", len_error, beat_count);
    end
  endtask

  task automatic test_pause;
    int i;
    int guard;
    int mirror_bad;
    int nbad;
    clear_log();
    pulse_start();
    i = 0;
    guard = 0;
    mirror_bad = 0;
    while (i < 8 && guard < 100) begin
      @(negedge clk);
      pause  = ~pause;
      tvalid = 1'b1;
      tdata  = 64'h50 + DW'(i);
      tlast  = (i == 7);
      #1;
      if (tready !== ~pause) mirror_bad++;
      if (tready === 1'b1) i++;
      guard++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    pause  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mirror_bad != 0 || i != 8) begin
      failures++;
      $display("FAIL pause_tready mismatched=%0d beats=%0d required 0 8", mirror_bad, i);
    end
    nbad = 0;
    foreach (wa_q[k]) begin
      if (wa_q[k] !== AW'(k) || wd_q[k] !== 64'h50 + DW'(k)) nbad++;
    end
    checks++;
    if (wa_q.size() != 8 || nbad != 0 || done_cnt != 1 || len_error !== 1'b0) begin
      failures++;
      $display("FAIL pause_writes count=%0d bad=%0d pulses=%0d len_err=%b required 8 0 1 0",
               wa_q.size(), nbad, done_cnt, len_error);
    end
  endtask

  task automatic test_reset_mid_frame;
    int nbad;
    clear_log();
    pulse_start();
    send_beats(4, -1, 64'h300);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (ram_wen !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || len_error !== 1'b0 ||
        beat_count !== 4'd0 || tready !== 1'b0 || ram_addr !== 4'd0 || ram_din !== 64'd0) begin
      failures++;
      $display("FAIL midreset_outputs wen=%b busy=%b done=%b lerr=%b cnt=%0d rdy=%b addr=%0d din=%h required all 0",
               ram_wen, busy, load_done, len_error, beat_count, tready, ram_addr, ram_din);
    end
    rst_n = 1'b1;
    clear_log();
    pulse_start();
    send_beats(8, 7, 64'h400);
    repeat (3) @(negedge clk);
    #1;
    nbad = 0;
    foreach (wa_q[k]) begin
      if (wa_q[k] !== AW'(k) || wd_q[k] !== 64'h400 + DW'(k)) nbad++;
    end
    checks++;
    if (wa_q.size() != 8 || nbad != 0 || done_cnt != 1 || len_error !== 1'b0) begin
      failures++;
      $display("FAIL midreset_reload count=%0d bad=%0d pulses=%0d len_err=%b required 8 0 1 0",
               wa_q.size(), nbad, done_cnt, len_error);
    end
  endtask

  task automatic test_idle_and_busy_start;
    int rdy_bad;
    int nbad;
    clear_log();
    rdy_bad = 0;
    repeat (3) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = 64'hDEAD;
      #1;
      if (tready !== 1'b0) rdy_bad++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rdy_bad != 0 || wa_q.size() != 0 || beat_count !== 4'd8) begin
      failures++;
      $display("FAIL idle_beats rdy_high=%0d writes=%0d count=%0d required 0 0 8",
               rdy_bad, wa_q.size(), beat_count);
    end
    pulse_start();
    send_beats(3, -1, 64'h100);
    pulse_start();
    checks++;
    if (beat_count !== 4'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_recv count=%0d busy=%b required 3 1", beat_count, busy);
    end
    send_beats(6, -1, 64'h103);
    pulse_start();
    checks++;
    if (len_error !== 1'b1 || beat_count !== 4'd8 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_drain len_err=%b count=%0d busy=%b required 1 8 1",
               len_error, beat_count, busy);
    end
    send_beats(1, 0, 64'h900);
    repeat (3) @(negedge clk);
    #1;
    nbad = 0;
    foreach (wa_q[k]) begin
      if (wa_q[k] !== AW'(k) || wd_q[k] !== 64'h100 + DW'(k)) nbad++;
    end
    checks++;
    if (wa_q.size() != 8 || nbad != 0 || done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_frame count=%0d bad=%0d pulses=%0d busy=%b required 8 0 1 0",
               wa_q.size(), nbad, done_cnt, busy);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    tstrb  = '1;
    tlast  = 1'b0;
    test_reset();
    test_clean_frame();
    test_short_frame();
    test_long_frame();
    test_pause();
    test_reset_mid_frame();
    test_idle_and_busy_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
